datapath_control_unit: RTL and testbench

Moore-style sequencer that drives the single-bus `Datapath` through fetch and execute steps, replacing hand-scripted control. Decodes the opcode in `IR` and emits the one-hot register-transfer, ALU-select and memory strobes for each step T0..T7. Sits beside `Datapath`, clocked by the same `clk`, and adds pause (`stop`) and halt handling.

---
 rtl/datapath_control_unit.sv | 167 ++++++++++++++++
 tb/tb_datapath_control_unit.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/datapath_control_unit.sv
// datapath_control_unit: Moore sequencer for the single-bus datapath.
// Walks fetch steps T0..T2, then decodes IR[31:27] and drives the execute
// steps T3..T7, with pause at instruction boundaries and a terminal halt.
// Every control output is a function of the current state and the opcode only.
module datapath_control_unit #(
  parameter bit STOP_EN = 1'b1
) (
  input  logic        clk,
  input  logic        clear,
  input  logic [31:0] IR,
  input  logic        stop,
  output logic        PCout,
  output logic        Zlowout,
  output logic        MDRout,
  output logic        Cout,
  output logic        BAout,
  output logic        Rout,
  output logic        MARin,
  output logic        Zin,
  output logic        PCin,
  output logic        MDRin,
  output logic        IRin,
  output logic        Yin,
  output logic        Rin,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        IncPC,
  output logic        Read,
  output logic        Write,
  output logic        ADD,
  output logic        SUB,
  output logic        AND,
  output logic        OR,
  output logic        SHR,
  output logic        SHL,
  output logic        ROR,
  output logic        ROL,
  output logic        NEG,
  output logic        NOT,
  output logic        run,
  output logic        instr_done,
  output logic        illegal_op,
  output logic [3:0]  state_o
);

  typedef enum logic [3:0] {
    S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_PAUSE, S_HALT
  } state_t;

  state_t state_q, state_d;

  logic [4:0] opc;
  logic       is_ld, is_ldi, is_st, is_alu3, is_imm, is_un, is_halt, is_nop, is_ill;
  logic [9:0] op_sel;  // {ADD,SUB,AND,OR,SHR,SHL,ROR,ROL,NEG,NOT}
  logic [9:0] alu;
  logic       done;
  logic       unused_ir;

  assign opc       = IR[31:27];
  assign unused_ir = ^IR[26:0];  // register fields are consumed by the datapath

  // Opcode class decode and ALU function select
  always_comb begin
    is_ld   = (opc == 5'd0);
    is_ldi  = (opc == 5'd1);
    is_st   = (opc == 5'd2);
    is_alu3 = (opc >= 5'd3) && (opc <= 5'd10);
    is_imm  = (opc >= 5'd11) && (opc <= 5'd13);
    is_un   = (opc == 5'd14) || (opc == 5'd15);
    is_nop  = (opc == 5'd26);
    is_halt = (opc == 5'd27);
    is_ill  = (opc > 5'd15) && !is_nop && !is_halt;
    op_sel  = 10'b0;
    case (opc)
      5'd3, 5'd11: op_sel = 10'b1000000000;
      5'd4:        op_sel = 10'b0100000000;
      5'd9, 5'd12: op_sel = 10'b0010000000;
      5'd10, 5'd13: op_sel = 10'b0001000000;
      5'd5:        op_sel = 10'b0000100000;
      5'd6:        op_sel = 10'b0000010000;
      5'd7:        op_sel = 10'b0000001000;
      5'd8:        op_sel = 10'b0000000100;
      5'd14:       op_sel = 10'b0000000010;
      5'd15:       op_sel = 10'b0000000001;
      default:     op_sel = 10'b0;
    endcase
  end

  // State register; clear forces RESET at once, zeroing every output
  always_ff @(posedge clk or posedge clear) begin
    if (clear) state_q <= S_RESET;
    else       state_q <= state_d;
  end

  // Per-step control decode and next-state selection
  always_comb begin
    PCout = 1'b0; Zlowout = 1'b0; MDRout = 1'b0; Cout = 1'b0; BAout = 1'b0;
    Rout = 1'b0; MARin = 1'b0; Zin = 1'b0; PCin = 1'b0; MDRin = 1'b0;
    IRin = 1'b0; Yin = 1'b0; Rin = 1'b0; Gra = 1'b0; Grb = 1'b0; Grc = 1'b0;
    IncPC = 1'b0; Read = 1'b0; Write = 1'b0;
    alu = 10'b0; done = 1'b0; illegal_op = 1'b0;
    state_d = state_q;
    case (state_q)
      S_RESET: state_d = S_T0;
      S_T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; state_d = S_T1; end
      S_T1: begin Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; state_d = S_T2; end
      S_T2: begin MDRout = 1'b1; IRin = 1'b1; state_d = S_T3; end
      S_T3: begin
        state_d = S_T4;
        if (is_ld || is_ldi || is_st) begin
          Grb = 1'b1; BAout = 1'b1; Yin = 1'b1;
        end else if (is_alu3 || is_imm) begin
          Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
        end else if (is_un) begin
          Grb = 1'b1; Rout = 1'b1; alu = op_sel; Zin = 1'b1;
        end else begin
          done = 1'b1;
          illegal_op = is_ill;
        end
      end
      S_T4: begin
        state_d = S_T5;
        if (is_ld || is_ldi || is_st) begin
          Cout = 1'b1; alu = 10'b1000000000; Zin = 1'b1;
        end else if (is_alu3) begin
          Grc = 1'b1; Rout = 1'b1; alu = op_sel; Zin = 1'b1;
        end else if (is_imm) begin
          Cout = 1'b1; alu = op_sel; Zin = 1'b1;
        end else begin
          Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; done = 1'b1;
        end
      end
      S_T5: begin
        state_d = S_T6;
        Zlowout = 1'b1;
        if (is_ld || is_st) MARin = 1'b1;
        else begin Gra = 1'b1; Rin = 1'b1; done = 1'b1; end
      end
      S_T6: begin
        state_d = S_T7;
        MDRin = 1'b1;
        if (is_st) begin Gra = 1'b1; Rout = 1'b1; end
        else       Read = 1'b1;
      end
      S_T7: begin
        done = 1'b1;
        if (is_st) Write = 1'b1;
        else begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
      end
      S_PAUSE: if (!stop) state_d = S_T0;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_RESET;
    endcase
    if (done) begin
      if (is_halt)              state_d = S_HALT;
      else if (STOP_EN && stop) state_d = S_PAUSE;
      else                      state_d = S_T0;
    end
  end

  assign {ADD, SUB, AND, OR, SHR, SHL, ROR, ROL, NEG, NOT} = alu;
  assign instr_done = done;
  assign run        = (state_q >= S_T0) && (state_q <= S_T7);
  assign state_o    = state_q;

endmodule

// File: tb/tb_datapath_control_unit.sv
// Bench for datapath_control_unit: per-cycle vector table of {IR, stop,
// expected outputs}, plus hand-written halt-hold and mid-instruction clear.
module tb_datapath_control_unit;

  logic        clk, clear, stop;
  logic [31:0] ir;
  logic PCout, Zlowout, MDRout, Cout, BAout, Rout, MARin, Zin, PCin, MDRin, IRin;
  logic Yin, Rin, Gra, Grb, Grc, IncPC, Read, Write;
  logic ADD, SUB, AND, OR, SHR, SHL, ROR, ROL, NEG, NOT, run, instr_done, illegal_op;
  logic [3:0]  state_o;
  logic [31:0] outs;

  int checks = 0;
  int failures = 0;

  localparam logic [31:0] M_PCOUT = 32'd1 << 31, M_ZLOWOUT = 32'd1 << 30,
    M_MDROUT = 32'd1 << 29, M_COUT = 32'd1 << 28, M_BAOUT = 32'd1 << 27,
    M_ROUT = 32'd1 << 26, M_MARIN = 32'd1 << 25, M_ZIN = 32'd1 << 24,
    M_PCIN = 32'd1 << 23, M_MDRIN = 32'd1 << 22, M_IRIN = 32'd1 << 21,
    M_YIN = 32'd1 << 20, M_RIN = 32'd1 << 19, M_GRA = 32'd1 << 18,
    M_GRB = 32'd1 << 17, M_GRC = 32'd1 << 16, M_INCPC = 32'd1 << 15,
    M_READ = 32'd1 << 14, M_WRITE = 32'd1 << 13, M_ADD = 32'd1 << 12,
    M_SUB = 32'd1 << 11, M_AND = 32'd1 << 10, M_OR = 32'd1 << 9,
    M_SHR = 32'd1 << 8, M_SHL = 32'd1 << 7, M_ROR = 32'd1 << 6,
    M_ROL = 32'd1 << 5, M_NEG = 32'd1 << 4, M_NOT = 32'd1 << 3,
    M_RUN = 32'd1 << 2, M_DONE = 32'd1 << 1, M_ILL = 32'd1;

  localparam logic [31:0] F0 = M_PCOUT | M_MARIN | M_INCPC | M_ZIN | M_RUN;
  localparam logic [31:0] F1 = M_ZLOWOUT | M_PCIN | M_READ | M_MDRIN | M_RUN;
  localparam logic [31:0] F2 = M_MDROUT | M_IRIN | M_RUN;
  localparam logic [31:0] WB = M_ZLOWOUT | M_GRA | M_RIN | M_RUN | M_DONE;

  localparam logic [31:0] I_LD = 32'h01000085, I_ADD = 32'h18A00000, I_ST = 32'h10800000,
    I_NEG = 32'h71000000, I_ILL = 32'hF8000000, I_HALT = 32'hD8000000,
    I_LDI = 32'h08000000, I_ORI = 32'h68000000, I_ROL = 32'h40000000,
    I_NOT = 32'h78000000, I_NOP = 32'hD0000000, I_SUB = 32'h20000000;

  typedef struct {
    logic [31:0] ir;
    logic        stp;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl[$];

  datapath_control_unit #(.STOP_EN(1'b1)) dut (
    .clk(clk), .clear(clear), .IR(ir), .stop(stop),
    .PCout(PCout), .Zlowout(Zlowout), .MDRout(MDRout), .Cout(Cout), .BAout(BAout),
    .Rout(Rout), .MARin(MARin), .Zin(Zin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin),
    .Yin(Yin), .Rin(Rin), .Gra(Gra), .Grb(Grb), .Grc(Grc), .IncPC(IncPC),
    .Read(Read), .Write(Write), .ADD(ADD), .SUB(SUB), .AND(AND), .OR(OR),
    .SHR(SHR), .SHL(SHL), .ROR(ROR), .ROL(ROL), .NEG(NEG), .NOT(NOT),
    .run(run), .instr_done(instr_done), .illegal_op(illegal_op), .state_o(state_o)
  );

  assign outs = {PCout, Zlowout, MDRout, Cout, BAout, Rout, MARin, Zin, PCin, MDRin,
                 IRin, Yin, Rin, Gra, Grb, Grc, IncPC, Read, Write, ADD, SUB, AND,
                 OR, SHR, SHL, ROR, ROL, NEG, NOT, run, instr_done, illegal_op};

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic v(input logic [31:0] i, input logic s, input logic [31:0] e);
    vec_t r;
    r.ir = i; r.stp = s; r.exp = e;
    tbl.push_back(r);
  endtask

  task automatic fetch(input logic [31:0] i, input logic s);
    v(i, s, F0); v(i, s, F1); v(i, s, F2);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  initial begin
    // ld: 8 cycles
    fetch(I_LD, 1'b0);
    v(I_LD, 1'b0, M_GRB | M_BAOUT | M_YIN | M_RUN);
    v(I_LD, 1'b0, M_COUT | M_ADD | M_ZIN | M_RUN);
    v(I_LD, 1'b0, M_ZLOWOUT | M_MARIN | M_RUN);
    v(I_LD, 1'b0, M_READ | M_MDRIN | M_RUN);
    v(I_LD, 1'b0, M_MDROUT | M_GRA | M_RIN | M_RUN | M_DONE);
    // add: 6 cycles
    fetch(I_ADD, 1'b0);
    v(I_ADD, 1'b0, M_GRB | M_ROUT | M_YIN | M_RUN);
    v(I_ADD, 1'b0, M_GRC | M_ROUT | M_ADD | M_ZIN | M_RUN);
    v(I_ADD, 1'b0, WB);
    // st: 8 cycles
    fetch(I_ST, 1'b0);
    v(I_ST, 1'b0, M_GRB | M_BAOUT | M_YIN | M_RUN);
    v(I_ST, 1'b0, M_COUT | M_ADD | M_ZIN | M_RUN);
    v(I_ST, 1'b0, M_ZLOWOUT | M_MARIN | M_RUN);
    v(I_ST, 1'b0, M_GRA | M_ROUT | M_MDRIN | M_RUN);
    v(I_ST, 1'b0, M_WRITE | M_RUN | M_DONE);
    // neg: 5 cycles
    fetch(I_NEG, 1'b0);
    v(I_NEG, 1'b0, M_GRB | M_ROUT | M_NEG | M_ZIN | M_RUN);
    v(I_NEG, 1'b0, WB);
    // illegal: 4 cycles
    fetch(I_ILL, 1'b0);
    v(I_ILL, 1'b0, M_RUN | M_DONE | M_ILL);
    // ldi
    fetch(I_LDI, 1'b0);
    v(I_LDI, 1'b0, M_GRB | M_BAOUT | M_YIN | M_RUN);
    v(I_LDI, 1'b0, M_COUT | M_ADD | M_ZIN | M_RUN);
    v(I_LDI, 1'b0, WB);
    // ori
    fetch(I_ORI, 1'b0);
    v(I_ORI, 1'b0, M_GRB | M_ROUT | M_YIN | M_RUN);
    v(I_ORI, 1'b0, M_COUT | M_OR | M_ZIN | M_RUN);
    v(I_ORI, 1'b0, WB);
    // rol with a stop pulse wholly inside the instruction: ignored
    fetch(I_ROL, 1'b1);
    v(I_ROL, 1'b0, M_GRB | M_ROUT | M_YIN | M_RUN);
    v(I_ROL, 1'b0, M_GRC | M_ROUT | M_ROL | M_ZIN | M_RUN);
    v(I_ROL, 1'b0, WB);
    // not
    fetch(I_NOT, 1'b0);
    v(I_NOT, 1'b0, M_GRB | M_ROUT | M_NOT | M_ZIN | M_RUN);
    v(I_NOT, 1'b0, WB);
    // nop
    fetch(I_NOP, 1'b0);
    v(I_NOP, 1'b0, M_RUN | M_DONE);
    // sub with stop raised in T4: pause after T5, resume when stop drops
    fetch(I_SUB, 1'b0);
    v(I_SUB, 1'b0, M_GRB | M_ROUT | M_YIN | M_RUN);
    v(I_SUB, 1'b1, M_GRC | M_ROUT | M_SUB | M_ZIN | M_RUN);
    v(I_SUB, 1'b1, WB);
    v(I_SUB, 1'b1, 32'h0);
    v(I_SUB, 1'b1, 32'h0);
    v(I_SUB, 1'b0, 32'h0);
    // halt
    fetch(I_HALT, 1'b0);
    v(I_HALT, 1'b0, M_RUN | M_DONE);
    v(I_HALT, 1'b1, 32'h0);

    // Reset phase
    clear = 1'b1; stop = 1'b0; ir = I_LD;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); #1;
      check($sformatf("reset%0d", k), outs, 32'h0);
    end
    @(negedge clk);
    clear = 1'b0;
    #1 check("reset_release", outs, 32'h0);

    // Table
    for (int n = 0; n < tbl.size(); n++) begin
      @(negedge clk);
      ir = tbl[n].ir;
      stop = tbl[n].stp;
      #1 check($sformatf("vec%0d", n), outs, tbl[n].exp);
    end

    // HALT holds regardless of stop until clear
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      stop = 1'($urandom_range(0, 1));
      #1 check($sformatf("halt_hold%0d", k), outs, 32'h0);
    end

    // clear exits HALT, then ld is cut off by clear in T6
    @(negedge clk);
    clear = 1'b1; stop = 1'b0; ir = I_LD;
    #1 check("halt_clear", outs, 32'h0);
    @(negedge clk);
    clear = 1'b0;
    #1 check("reclear_release", outs, 32'h0);
    @(negedge clk); #1 check("ld2_t0", outs, F0);
    for (int k = 0; k < 6; k++) @(negedge clk);
    #1 check("ld2_t6", outs, M_READ | M_MDRIN | M_RUN);
    #2 clear = 1'b1;
    #1 check("async_clear", outs, 32'h0);
    @(negedge clk); #1 check("clear_hold", outs, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
